score_display_mux: RTL and testbench
====================================

Name: score_display_mux

Overview:
- Parametrised multi-player, multi-digit score display driver for the ping-pong game.
- Accepts binary scores and converts them to BCD with a sequential double-dabble engine.
- Time-multiplexes all digits onto one shared 7-segment bus with one-hot digit enables.
- Supports leading-zero blanking, per-player blink (win/serve indication) and saturation.
- Sits between the game-state/score logic and the board's segment/anode pins.

Parameters:
- NUM_PLAYERS, 2, number of score channels (1..4).
- SCORE_W, 7, width of each binary score input.
- DIGITS, 2, BCD digits shown per player (1..3).
- SCAN_DIV, 2, tick_1ms pulses per digit slot.
- BLINK_DIV, 250, tick_1ms pulses per blink half-period.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-low reset (0 = reset).
- tick_1ms  in  1  single-cycle 1 ms enable strobe.
- score_in  in  NUM_PLAYERS*SCORE_W  packed binary scores; player p occupies bits [p*SCORE_W +: SCORE_W].
- score_valid  in  1  1-cycle pulse to latch score_in.
- blink_mask  in  NUM_PLAYERS  bit p=1 blinks player p's digits.
- seg  out  7  segments gfedcba, active-low.
- an  out  NUM_PLAYERS*DIGITS  digit enables, one-hot active-low.
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset (reset=0 at clk edge):
  - seg=7'b1111111, an all 1s, busy=0.
  - Committed and working BCD cleared to 0; scan index, scan counter, blink counter and blink phase all 0.
  - An in-flight conversion is aborted and nothing is committed.
- Latch:
  - score_valid=1 copies score_in into the shadow register and sets busy=1 on the next cycle.
  - A score_valid while busy re-latches and restarts the conversion. Last write wins; the partial result is discarded.
- Conversion:
  - Players are converted sequentially, p=0 first. Each takes SCORE_W cycles of shift-and-add-3 on DIGITS nibbles.
  - A score greater than 10^DIGITS-1 saturates to all 9s, using an overflow flag set during the shifts.
  - After the last player, all players' BCD is committed atomically in one cycle and busy falls in that same cycle.
  - Total latency is NUM_PLAYERS*SCORE_W+1 clocks from the score_valid edge to new digits on the bus.
  - The display keeps showing the previous committed values until the commit.
- Scan:
  - Slot index k = p*DIGITS + d, where d=0 is the ones digit.
  - The scan counter counts tick_1ms pulses. At SCAN_DIV-1 it wraps to 0 and k advances; k wraps from NUM_PLAYERS*DIGITS-1 to 0.
  - an[k]=0 for the current slot and all other bits are 1. an and seg change in the same cycle with no skew.
- Encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking:
  - Digit d>0 shows seg=1111111 when it and all higher digits of that player are 0.
  - The ones digit is never blanked.
- Blink:
  - The blink counter counts tick_1ms pulses and toggles the phase at BLINK_DIV-1.
  - When phase=1 and blink_mask[p]=1, all of player p's digits output seg=1111111; an still scans.
  - blink_mask is sampled live and is not latched.
- Simultaneous events:
  - score_valid with reset=0: reset wins.
  - tick_1ms during a conversion: scanning continues normally.

Optional Feature:
- Macro: SCORE_DISPLAY_DP_EN.
- With the macro defined:
  - Adds input serve (width NUM_PLAYERS, one-hot) and output dp (1, active-low).
  - dp=0 when the current slot is the ones digit of the player with serve[p]=1, otherwise dp=1.
  - dp follows the blink blanking for that player; dp=1 in reset.
- Without the macro: no serve or dp ports exist and the logic is unchanged otherwise.

Test Plan:
- Reset then release: seg=1111111 and an=all 1s during reset. The first scanned slot after release shows player 0 ones digit "0" (1000000) with an=...1110.
- score_in={p1=7'd12, p0=7'd5}, score_valid pulse:
  - busy=1 for 14 cycles; commit at cycle 15.
  - Slot 0 shows "5", slot 1 is blank (leading zero), slot 2 shows "2" (0100100), slot 3 shows "1" (1111001).
- score p0=7'd127 with DIGITS=2: the display shows "99" for player 0.
- Second score_valid 5 cycles after the first (p0=3, then p0=8): busy stays high until 14 cycles after the second pulse, only "8" is ever committed, and "3" never appears.
- blink_mask=2'b10, BLINK_DIV=4: player 1 slots are blank for 4 ticks and visible for 4 ticks alternately; player 0 is always visible.
- reset asserted mid-conversion: busy=0 and BCD=0 the next cycle, and the old score is not committed after release.

Source files
------------

// File: rtl/score_display_mux.sv
// score_display_mux: multi-player BCD score display driver.
// Binary scores are latched on score_valid and converted to BCD one player
// at a time by a shift-and-add-3 engine. Scores that do not fit in DIGITS
// decimal digits saturate to all nines. All players' digits are committed
// together, then time-multiplexed onto one active-low 7-segment bus with
// one-hot active-low digit enables, leading-zero blanking and per-player blink.
// Optional build macro SCORE_DISPLAY_DP_EN adds a serve input and a
// decimal-point output lit on the serving player's ones digit.
module score_display_mux #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 7,
    parameter int DIGITS      = 2,
    parameter int SCAN_DIV    = 2,
    parameter int BLINK_DIV   = 250
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tick_1ms,
    input  logic [NUM_PLAYERS*SCORE_W-1:0]  score_in,
    input  logic                            score_valid,
    input  logic [NUM_PLAYERS-1:0]          blink_mask,
`ifdef SCORE_DISPLAY_DP_EN
    input  logic [NUM_PLAYERS-1:0]          serve,
    output logic                            dp,
`endif
    output logic [6:0]                      seg,
    output logic [NUM_PLAYERS*DIGITS-1:0]   an,
    output logic                            busy
);

    localparam int NUM_SLOTS = NUM_PLAYERS * DIGITS;
    localparam int BCD_W     = DIGITS * 4;
    localparam int P_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int D_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int K_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int B_W       = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam int SC_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BL_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [P_W-1:0]   P_LAST   = P_W'(NUM_PLAYERS - 1);
    localparam logic [D_W-1:0]   D_LAST   = D_W'(DIGITS - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(NUM_SLOTS - 1);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(SCORE_W - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_DIV - 1);
    localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_DIV - 1);
    localparam logic [BCD_W-1:0] SAT_BCD  = {DIGITS{4'd9}};

    // Active-low 7-segment pattern (gfedcba) for one BCD digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

    // Conversion engine state
    logic [NUM_PLAYERS*SCORE_W-1:0] shadow_r;
    logic                           busy_r;
    logic [P_W-1:0]                 conv_p_r;
    logic [B_W-1:0]                 conv_bit_r;
    logic [SCORE_W-1:0]             conv_bin_r;
    logic [BCD_W-1:0]               conv_bcd_r;
    logic                           conv_ovf_r;
    logic [BCD_W-1:0]               work_bcd_r [NUM_PLAYERS];
    logic [BCD_W-1:0]               com_bcd_r  [NUM_PLAYERS];

    logic [BCD_W-1:0]               adj_bcd_s;
    logic [BCD_W-1:0]               step_bcd_s;
    logic [SCORE_W-1:0]             step_bin_s;
    logic                           step_ovf_s;
    logic [BCD_W-1:0]               result_s;
    logic [NUM_PLAYERS*SCORE_W-1:0] shadow_next_s;

    // Scan / blink state
    logic [SC_W-1:0]                scan_cnt_r;
    logic [K_W-1:0]                 scan_k_r;
    logic [P_W-1:0]                 scan_p_r;
    logic [D_W-1:0]                 scan_d_r;
    logic [BL_W-1:0]                blink_cnt_r;
    logic                           blink_phase_r;

    // Display path
    logic [BCD_W-1:0]               cur_bcd_s;
    logic [3:0]                     nibble_s;
    logic                           zero_above_s;
    logic                           blank_s;
    logic [6:0]                     seg_s;
    logic [NUM_SLOTS-1:0]           an_s;
    logic [6:0]                     seg_r;
    logic [NUM_SLOTS-1:0]           an_r;

    // One double-dabble step: add 3 to nibbles >= 5, then shift the next binary bit in.
    // A bit carried out of the top nibble means the score exceeds the display range.
    always_comb begin
        adj_bcd_s = conv_bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            adj_bcd_s[i*4 +: 4] = (conv_bcd_r[i*4 +: 4] >= 4'd5) ?
                                  (conv_bcd_r[i*4 +: 4] + 4'd3) : conv_bcd_r[i*4 +: 4];
        end
        step_bcd_s    = {adj_bcd_s[BCD_W-2:0], conv_bin_r[SCORE_W-1]};
        step_ovf_s    = conv_ovf_r | adj_bcd_s[BCD_W-1];
        step_bin_s    = conv_bin_r << 1;
        result_s      = step_ovf_s ? SAT_BCD : step_bcd_s;
        shadow_next_s = shadow_r >> SCORE_W;
    end

    // Latch scores, run the per-player conversion and commit all players at once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_r   <= '0;
            busy_r     <= 1'b0;
            conv_p_r   <= '0;
            conv_bit_r <= '0;
            conv_bin_r <= '0;
            conv_bcd_r <= '0;
            conv_ovf_r <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                work_bcd_r[i] <= '0;
                com_bcd_r[i]  <= '0;
            end
        end else if (score_valid) begin
            // a new score always restarts from player 0, discarding partial work
            shadow_r   <= score_in;
            busy_r     <= 1'b1;
            conv_p_r   <= '0;
            conv_bit_r <= '0;
            conv_bin_r <= score_in[SCORE_W-1:0];
            conv_bcd_r <= '0;
            conv_ovf_r <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                work_bcd_r[i] <= '0;
            end
        end else if (busy_r) begin
            if (conv_bit_r == B_LAST) begin
                work_bcd_r[conv_p_r] <= result_s;
                conv_bit_r <= '0;
                conv_bcd_r <= '0;
                conv_ovf_r <= 1'b0;
                if (conv_p_r == P_LAST) begin
                    busy_r <= 1'b0;
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        com_bcd_r[i] <= (P_W'(i) == conv_p_r) ? result_s : work_bcd_r[i];
                    end
                end else begin
                    conv_p_r   <= conv_p_r + 1'b1;
                    shadow_r   <= shadow_next_s;
                    conv_bin_r <= shadow_next_s[SCORE_W-1:0];
                end
            end else begin
                conv_bit_r <= conv_bit_r + 1'b1;
                conv_bin_r <= step_bin_s;
                conv_bcd_r <= step_bcd_s;
                conv_ovf_r <= step_ovf_s;
            end
        end else begin
            conv_bit_r <= conv_bit_r;
        end
    end

    // Advance the scanned slot every SCAN_DIV ticks; slot, player and digit move together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt_r <= '0;
            scan_k_r   <= '0;
            scan_p_r   <= '0;
            scan_d_r   <= '0;
        end else if (tick_1ms) begin
            if (scan_cnt_r == SC_LAST) begin
                scan_cnt_r <= '0;
                if (scan_k_r == K_LAST) begin
                    scan_k_r <= '0;
                    scan_p_r <= '0;
                    scan_d_r <= '0;
                end else begin
                    scan_k_r <= scan_k_r + 1'b1;
                    if (scan_d_r == D_LAST) begin
                        scan_d_r <= '0;
                        scan_p_r <= scan_p_r + 1'b1;
                    end else begin
                        scan_d_r <= scan_d_r + 1'b1;
                    end
                end
            end else begin
                scan_cnt_r <= scan_cnt_r + 1'b1;
            end
        end else begin
            scan_cnt_r <= scan_cnt_r;
        end
    end

    // Toggle the blink phase every BLINK_DIV ticks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (tick_1ms) begin
            if (blink_cnt_r == BL_LAST) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + 1'b1;
            end
        end else begin
            blink_cnt_r <= blink_cnt_r;
        end
    end

    // Select the scanned digit, apply leading-zero and blink blanking, build enables.
    always_comb begin
        cur_bcd_s    = com_bcd_r[scan_p_r];
        nibble_s     = 4'd0;
        zero_above_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nibble_s     = (D_W'(i) == scan_d_r) ? cur_bcd_s[i*4 +: 4] : nibble_s;
            zero_above_s = zero_above_s &
                           ~((D_W'(i) >= scan_d_r) & (cur_bcd_s[i*4 +: 4] != 4'd0));
        end
        blank_s = ((scan_d_r != '0) & zero_above_s) |
                  (blink_phase_r & blink_mask[scan_p_r]);
        seg_s   = blank_s ? 7'b1111111 : seg_encode(nibble_s);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            an_s[i] = (K_W'(i) != scan_k_r);
        end
    end

    // Register seg and an together so the bus never shows skew between them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_r <= 7'b1111111;
            an_r  <= '1;
        end else begin
            seg_r <= seg_s;
            an_r  <= an_s;
        end
    end

`ifdef SCORE_DISPLAY_DP_EN
    logic dp_s;
    logic dp_r;

    // Light the decimal point on the serving player's ones digit unless blinked off.
    always_comb begin
        dp_s = ~((scan_d_r == '0) & serve[scan_p_r] &
                 ~(blink_phase_r & blink_mask[scan_p_r]));
    end

    // Register dp alongside seg/an.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dp_r <= 1'b1;
        end else begin
            dp_r <= dp_s;
        end
    end

    assign dp = dp_r;
`endif

    assign seg  = seg_r;
    assign an   = an_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_score_display_mux.sv
// Self-checking bench for score_display_mux: directed scenarios followed by
// randomized traffic, every cycle compared against a decimal-arithmetic model.
module tb_score_display_mux;

    localparam int NP   = 2;
    localparam int SW   = 7;
    localparam int DG   = 2;
    localparam int SDIV = 2;
    localparam int BDIV = 4;
    localparam int NSL  = NP * DG;

    logic              clk;
    logic              reset;
    logic              tick_1ms;
    logic [NP*SW-1:0]  score_in;
    logic              score_valid;
    logic [NP-1:0]     blink_mask;
    logic [6:0]        seg;
    logic [NSL-1:0]    an;
    logic              busy;
`ifdef SCORE_DISPLAY_DP_EN
    logic [NP-1:0]     serve;
    logic              dp;
`endif

    score_display_mux #(
        .NUM_PLAYERS(NP), .SCORE_W(SW), .DIGITS(DG),
        .SCAN_DIV(SDIV), .BLINK_DIV(BDIV)
    ) dut (
        .clk(clk), .reset(reset), .tick_1ms(tick_1ms),
        .score_in(score_in), .score_valid(score_valid), .blink_mask(blink_mask),
`ifdef SCORE_DISPLAY_DP_EN
        .serve(serve), .dp(dp),
`endif
        .seg(seg), .an(an), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    int vec_cnt = 0;
    int err_cnt = 0;

    // reference model state
    int committed [NP];
    int pend [NP];
    int remaining;
    int ticks;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // expected bus contents from the model's current state
    task automatic expect_display(input logic [NP-1:0] bm, input logic [NP-1:0] sv,
                                  output logic [6:0] es, output logic [NSL-1:0] ea,
                                  output logic ed);
        int k, p, d, val, maxv, pw, digit;
        bit blank, phase;
        k = (ticks / SDIV) % NSL;
        p = k / DG;
        d = k % DG;
        maxv = 1;
        for (int j = 0; j < DG; j++) maxv = maxv * 10;
        maxv = maxv - 1;
        pw = 1;
        for (int j = 0; j < d; j++) pw = pw * 10;
        val = (committed[p] > maxv) ? maxv : committed[p];
        digit = (val / pw) % 10;
        phase = ((ticks / BDIV) % 2) == 1;
        blank = ((d > 0) && (val < pw)) || (phase && bm[p]);
        es = blank ? 7'b1111111 : seg_tab[digit];
        ea = '1;
        ea[k] = 1'b0;
        ed = !((d == 0) && sv[p] && !(phase && bm[p]));
    endtask

    // apply one clock of stimulus, advance the model, compare outputs
    task automatic step(input logic rst, input logic v, input logic [NP*SW-1:0] sc,
                        input logic tk, input logic [NP-1:0] bm, input logic [NP-1:0] sv);
        logic [6:0] es;
        logic [NSL-1:0] ea;
        logic ed;
        reset = rst; score_valid = v; score_in = sc; tick_1ms = tk; blink_mask = bm;
`ifdef SCORE_DISPLAY_DP_EN
        serve = sv;
`endif
        expect_display(bm, sv, es, ea, ed);
        if (!rst) begin
            es = 7'b1111111;
            ea = '1;
            ed = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < NP; i++) committed[i] = 0;
            remaining = 0;
            ticks = 0;
        end else begin
            if (v) begin
                for (int i = 0; i < NP; i++) pend[i] = int'(sc[i*SW +: SW]);
                remaining = NP * SW;
            end else if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    for (int i = 0; i < NP; i++) committed[i] = pend[i];
                end
            end
            if (tk) ticks++;
        end
        check_value("busy", 32'(busy), 32'(remaining > 0));
        check_value("seg", 32'(seg), 32'(es));
        check_value("an", 32'(an), 32'(ea));
`ifdef SCORE_DISPLAY_DP_EN
        check_value("dp", 32'(dp), 32'(ed));
`endif
    endtask

    function automatic logic [NP*SW-1:0] scores(input int p1, input int p0);
        logic [NP*SW-1:0] s;
        s = '0;
        s[0 +: SW]  = SW'(p0);
        s[SW +: SW] = SW'(p1);
        return s;
    endfunction

    initial begin
        logic [NP-1:0] bm;
        logic [NP-1:0] sv;
        logic [NP*SW-1:0] rs;
        for (int i = 0; i < NP; i++) begin
            committed[i] = 0;
            pend[i] = 0;
        end
        remaining = 0;
        ticks = 0;
        sv = 2'b01;

        // reset, then release with blank display scanning from slot 0
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, 2'b00, sv);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1, 2'b00, sv);

        // p1=12, p0=5
        step(1'b1, 1'b1, scores(12, 5), 1'b0, 2'b00, sv);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, '0, 1'b1, 2'b00, sv);

        // saturation: 127 shows as 99
        step(1'b1, 1'b1, scores(0, 127), 1'b0, 2'b00, sv);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, '0, 1'b1, 2'b00, sv);

        // restart: 3 then 8 five cycles later
        step(1'b1, 1'b1, scores(0, 3), 1'b1, 2'b00, sv);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1, 2'b00, sv);
        step(1'b1, 1'b1, scores(0, 8), 1'b1, 2'b00, sv);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, '0, 1'b1, 2'b00, sv);

        // blink player 1
        step(1'b1, 1'b1, scores(45, 67), 1'b0, 2'b10, sv);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, '0, 1'b1, 2'b10, sv);

        // reset in the middle of a conversion
        step(1'b1, 1'b1, scores(99, 77), 1'b1, 2'b00, sv);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1, 2'b00, sv);
        step(1'b0, 1'b1, scores(11, 22), 1'b1, 2'b00, sv);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, '0, 1'b1, 2'b00, sv);

        // randomized traffic
        bm = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) bm = NP'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) sv = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            rs = scores(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
            step(($urandom_range(0, 399) != 0), ($urandom_range(0, 24) == 0), rs,
                 ($urandom_range(0, 2) == 0), bm, sv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
